// File: rtl/noc_vc_credit_sched_if.sv
// Request/link handshake bundle for the VC credit scheduler.
// The master side supplies the VC requests and the link ready. The slave side is the scheduler.
interface noc_vc_credit_sched_if #(
  parameter int N = 4
);
  localparam int VW = $clog2(N);

  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_tail;
  logic [N-1:0]  req_ready;
  logic          out_valid;
  logic [VW-1:0] out_vc;
  logic          out_tail;
  logic          out_ready;

  modport master (
    output req_valid, req_tail, out_ready,
    input  req_ready, out_valid, out_vc, out_tail
  );

  modport slave (
    input  req_valid, req_tail, out_ready,
    output req_ready, out_valid, out_vc, out_tail
  );
endinterface

// File: rtl/noc_vc_credit_sched.sv
// Round-robin output-link scheduler with per-VC downstream credits.
// Wormhole packet locking is enabled by defining NOC_PKT_LOCK_EN.
module noc_vc_credit_sched #(
  parameter int N     = 4,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  noc_vc_credit_sched_if.slave  bus,
  input  logic [N-1:0]          credit_ret,
  output logic [N*CW-1:0]       credit_cnt,
  output logic                  locked,
  output logic                  credit_err
);
  localparam int VW = $clog2(N);

  logic [VW-1:0] ptr_r;
  logic [CW-1:0] credit_r [N];
  logic          credit_err_r;

  logic [N-1:0]  eligible_s;
  logic [N-1:0]  consume_s;
  logic          found_s;
  logic [VW-1:0] winner_s;
  logic          xfer_s;
  logic [VW-1:0] ptr_nxt_s;
  logic [CW-1:0] credit_nxt_s [N];
  logic          ovf_s;

`ifdef NOC_PKT_LOCK_EN
  logic          locked_r;
  logic [VW-1:0] owner_r;
`endif

  // Returns {found, index} of the first set bit scanning start, start+1, ... mod N.
  function automatic logic [VW:0] rr_pick(input logic [N-1:0] elig, input logic [VW-1:0] start);
    logic [VW:0] res;
    int          idx;
    res = {(VW+1){1'b0}};
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(start) + k) % N;
      if (elig[idx]) begin
        res = {1'b1, idx[VW-1:0]};
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // A VC may compete only when it has a flit and a downstream slot.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      eligible_s[i] = bus.req_valid[i] & (credit_r[i] != {CW{1'b0}});
    end
  end

  // Winner selection; a held lock pins the link to its owner.
  always_comb begin
    logic [VW:0] pick;
    pick = rr_pick(eligible_s, ptr_r);
`ifdef NOC_PKT_LOCK_EN
    if (locked_r) begin
      found_s  = eligible_s[owner_r];
      winner_s = owner_r;
    end else begin
      found_s  = pick[VW];
      winner_s = pick[VW-1:0];
    end
`else
    found_s  = pick[VW];
    winner_s = pick[VW-1:0];
`endif
  end

  // Link-side outputs and the one-hot accept back to the winning VC.
  always_comb begin
    xfer_s        = found_s & bus.out_ready;
    bus.out_valid = found_s;
    bus.out_vc    = found_s ? winner_s : {VW{1'b0}};
    bus.out_tail  = found_s ? bus.req_tail[winner_s] : 1'b0;
    bus.req_ready = {N{1'b0}};
    if (xfer_s) begin
      bus.req_ready[winner_s] = 1'b1;
    end else begin
      bus.req_ready = {N{1'b0}};
    end
  end

  // Credit arithmetic; a return into a full counter saturates and flags an error.
  always_comb begin
    ovf_s     = 1'b0;
    ptr_nxt_s = (winner_s == VW'(N - 1)) ? {VW{1'b0}} : winner_s + VW'(1);
    for (int i = 0; i < N; i++) begin
      consume_s[i]    = xfer_s & (winner_s == VW'(i));
      credit_nxt_s[i] = credit_r[i];
      if (credit_ret[i] && !consume_s[i]) begin
        if (credit_r[i] == CW'(DEPTH)) begin
          ovf_s = 1'b1;
        end else begin
          credit_nxt_s[i] = credit_r[i] + CW'(1);
        end
      end else if (!credit_ret[i] && consume_s[i]) begin
        credit_nxt_s[i] = credit_r[i] - CW'(1);
      end else begin
        credit_nxt_s[i] = credit_r[i];
      end
    end
  end

  // Pointer, credit counters and sticky error register.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r        <= {VW{1'b0}};
      credit_err_r <= 1'b0;
      for (int i = 0; i < N; i++) begin
        credit_r[i] <= CW'(DEPTH);
      end
    end else begin
      if (xfer_s) begin
        ptr_r <= ptr_nxt_s;
      end
      credit_err_r <= credit_err_r | ovf_s;
      for (int i = 0; i < N; i++) begin
        credit_r[i] <= credit_nxt_s[i];
      end
    end
  end

`ifdef NOC_PKT_LOCK_EN
  // Packet lock: a non-tail transfer claims the link, a tail releases it.
  always_ff @(posedge clk) begin
    if (rst) begin
      locked_r <= 1'b0;
      owner_r  <= {VW{1'b0}};
    end else if (xfer_s) begin
      locked_r <= ~bus.out_tail;
      if (!bus.out_tail) begin
        owner_r <= winner_s;
      end
    end
  end

  assign locked = locked_r;
`else
  assign locked = 1'b0;
`endif

  // Flatten the counters onto the status bus.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      credit_cnt[i*CW +: CW] = credit_r[i];
    end
  end

  assign credit_err = credit_err_r;
endmodule

// File: tb/tb_noc_vc_credit_sched.sv
// Directed self-checking bench for noc_vc_credit_sched (N=4, DEPTH=2).
// Expected values follow the NOC_PKT_LOCK_EN setting of the build.
module tb_noc_vc_credit_sched;
  localparam int N     = 4;
  localparam int DEPTH = 2;
  localparam int CW    = 2;
`ifdef NOC_PKT_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  credit_ret;
  logic [N*CW-1:0] credit_cnt;
  logic          locked;
  logic          credit_err;
  int            n_checks = 0;
  int            n_fail   = 0;

  noc_vc_credit_sched_if #(.N(N)) bus ();

  noc_vc_credit_sched #(.N(N), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .credit_ret (credit_ret),
    .credit_cnt (credit_cnt),
    .locked     (locked),
    .credit_err (credit_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] req, input logic [3:0] tail,
                       input logic [3:0] ret, input logic rdy);
    bus.req_valid = req;
    bus.req_tail  = tail;
    credit_ret    = ret;
    bus.out_ready = rdy;
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(4'b0000, 4'b0000, 4'b0000, 1'b1);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] oh;
    rst           = 1'b1;
    bus.req_valid = 4'b0000;
    bus.req_tail  = 4'b0000;
    bus.out_ready = 1'b0;
    credit_ret    = 4'b0000;

    // Reset state
    tick();
    drive(4'b0000, 4'b0000, 4'b0000, 1'b1);
    check_eq("rst_credits", 32'(credit_cnt), 32'h000000AA);
    check_eq("rst_locked", 32'(locked), 32'd0);
    check_eq("rst_err", 32'(credit_err), 32'd0);
    check_eq("rst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_vc", 32'(bus.out_vc), 32'd0);
    rst = 1'b0;

    // 1: all VCs, single-flit packets, credits echoed in the same cycle
    for (int k = 0; k < 6; k++) begin
      oh = 4'b0001 << (k % 4);
      drive(4'b1111, 4'b1111, oh, 1'b1);
      check_eq("rr_valid", 32'(bus.out_valid), 32'd1);
      check_eq("rr_vc", 32'(bus.out_vc), 32'(k % 4));
      check_eq("rr_ready", 32'(bus.req_ready), 32'(oh));
      tick();
    end
    drive(4'b0000, 4'b0000, 4'b0000, 1'b1);
    check_eq("rr_credits", 32'(credit_cnt), 32'h000000AA);
    check_eq("rr_err", 32'(credit_err), 32'd0);

    // 2: VC1 head/body/tail against a constantly requesting VC2
    do_reset();
    drive(4'b0110, 4'b0100, 4'b0010, 1'b1);
    check_eq("pkt_a_vc", 32'(bus.out_vc), 32'd1);
    check_eq("pkt_a_tail", 32'(bus.out_tail), 32'd0);
    check_eq("pkt_a_locked", 32'(locked), 32'd0);
    tick();
    oh = LOCK_EN ? 4'b0010 : 4'b0100;
    drive(4'b0110, 4'b0100, oh, 1'b1);
    check_eq("pkt_b_vc", 32'(bus.out_vc), LOCK_EN ? 32'd1 : 32'd2);
    check_eq("pkt_b_tail", 32'(bus.out_tail), LOCK_EN ? 32'd0 : 32'd1);
    check_eq("pkt_b_locked", 32'(locked), 32'(LOCK_EN));
    tick();
    drive(4'b0110, 4'b0110, 4'b0010, 1'b1);
    check_eq("pkt_c_vc", 32'(bus.out_vc), 32'd1);
    check_eq("pkt_c_tail", 32'(bus.out_tail), 32'd1);
    check_eq("pkt_c_locked", 32'(locked), 32'(LOCK_EN));
    tick();
    drive(4'b0100, 4'b0100, 4'b0100, 1'b1);
    check_eq("pkt_d_vc", 32'(bus.out_vc), 32'd2);
    check_eq("pkt_d_locked", 32'(locked), 32'd0);
    tick();

    // 3: credit exhaustion on VC0 and recovery by one return
    do_reset();
    drive(4'b0001, 4'b0001, 4'b0000, 1'b1);
    check_eq("cx_1_valid", 32'(bus.out_valid), 32'd1);
    tick();
    drive(4'b0001, 4'b0001, 4'b0000, 1'b1);
    check_eq("cx_2_valid", 32'(bus.out_valid), 32'd1);
    check_eq("cx_2_credit", 32'(credit_cnt[1:0]), 32'd1);
    tick();
    drive(4'b0001, 4'b0001, 4'b0000, 1'b1);
    check_eq("cx_3_valid", 32'(bus.out_valid), 32'd0);
    check_eq("cx_3_credit", 32'(credit_cnt[1:0]), 32'd0);
    check_eq("cx_3_ready", 32'(bus.req_ready), 32'd0);
    tick();
    drive(4'b0001, 4'b0001, 4'b0001, 1'b1);
    check_eq("cx_4_valid", 32'(bus.out_valid), 32'd0);
    tick();
    drive(4'b0001, 4'b0001, 4'b0000, 1'b1);
    check_eq("cx_5_valid", 32'(bus.out_valid), 32'd1);
    check_eq("cx_5_credit", 32'(credit_cnt[1:0]), 32'd1);
    tick();
    drive(4'b0001, 4'b0001, 4'b0000, 1'b1);
    check_eq("cx_6_valid", 32'(bus.out_valid), 32'd0);
    check_eq("cx_6_credit", 32'(credit_cnt[1:0]), 32'd0);
    tick();

    // 4: simultaneous return and consume, then overflow
    do_reset();
    drive(4'b1000, 4'b1000, 4'b0000, 1'b1);
    check_eq("ov_1_vc", 32'(bus.out_vc), 32'd3);
    tick();
    drive(4'b1000, 4'b1000, 4'b1000, 1'b1);
    check_eq("ov_2_credit", 32'(credit_cnt[7:6]), 32'd1);
    check_eq("ov_2_ready", 32'(bus.req_ready), 32'h8);
    tick();
    drive(4'b0000, 4'b0000, 4'b0001, 1'b1);
    check_eq("ov_3_credit", 32'(credit_cnt[7:6]), 32'd1);
    check_eq("ov_3_err_before", 32'(credit_err), 32'd0);
    tick();
    drive(4'b0000, 4'b0000, 4'b0000, 1'b1);
    check_eq("ov_4_err", 32'(credit_err), 32'd1);
    check_eq("ov_4_credit0", 32'(credit_cnt[1:0]), 32'd2);
    tick();
    check_eq("ov_5_err_sticky", 32'(credit_err), 32'd1);

    // 5: backpressure holds the grant without state change
    do_reset();
    for (int k = 0; k < 3; k++) begin
      drive(4'b0110, 4'b0110, 4'b0000, 1'b0);
      check_eq("bp_valid", 32'(bus.out_valid), 32'd1);
      check_eq("bp_vc", 32'(bus.out_vc), 32'd1);
      check_eq("bp_ready", 32'(bus.req_ready), 32'd0);
      check_eq("bp_credits", 32'(credit_cnt), 32'h000000AA);
      tick();
    end
    drive(4'b0110, 4'b0110, 4'b0000, 1'b1);
    check_eq("bp_go_ready", 32'(bus.req_ready), 32'h2);
    tick();
    drive(4'b0110, 4'b0110, 4'b0000, 1'b1);
    check_eq("bp_ptr_vc", 32'(bus.out_vc), 32'd2);
    check_eq("bp_credit1", 32'(credit_cnt[3:2]), 32'd1);
    tick();

    // 6: reset in the middle of a packet
    do_reset();
    drive(4'b0010, 4'b0000, 4'b0000, 1'b1);
    check_eq("mr_head_vc", 32'(bus.out_vc), 32'd1);
    tick();
    drive(4'b0000, 4'b0000, 4'b0000, 1'b1);
    check_eq("mr_locked", 32'(locked), 32'(LOCK_EN));
    check_eq("mr_credit1", 32'(credit_cnt[3:2]), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(4'b1001, 4'b1001, 4'b0000, 1'b1);
    check_eq("mr_unlocked", 32'(locked), 32'd0);
    check_eq("mr_credits", 32'(credit_cnt), 32'h000000AA);
    check_eq("mr_valid", 32'(bus.out_valid), 32'd1);
    check_eq("mr_vc", 32'(bus.out_vc), 32'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
